// File: rtl/char_div_pkg.sv
// char_div_pkg: shared types and default constants for char_division_gen.
//   state_t       - calculation FSM states
//   DEF_*         - default fraction numerators/shifts and per-line trims
//   trim_slice()  - extracts the signed 8-bit trim for partition line k
package char_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC_V,
    CALC_ROW,
    CALC_H,
    COMMIT
  } state_t;

  localparam int unsigned DEF_FIRST_NUM  = 21;
  localparam int unsigned DEF_PITCH_NUM  = 9;
  localparam int unsigned DEF_H_SHIFT    = 6;
  localparam int unsigned DEF_MARGIN_NUM = 3;
  localparam int unsigned DEF_V_SHIFT    = 5;
  localparam int unsigned DEF_ROW1_NUM   = 5;
  localparam int unsigned DEF_ROW2_NUM   = 12;
  localparam int unsigned DEF_ROW_SHIFT  = 4;

  // Largest partition-line count the trim helper can address.
  localparam int unsigned MAX_LINES  = 15;
  localparam int unsigned TRIM_MAX_W = MAX_LINES * 8;

  // Slice k sits at bits [k*8 +: 8]; line 5 = -11, 4 = -4, 3 = -2, 2..0 = 0.
  localparam logic [47:0] DEF_TRIM = {8'hF5, 8'hFC, 8'hFE, 8'h00, 8'h00, 8'h00};

  function automatic logic signed [7:0] trim_slice(input logic [TRIM_MAX_W-1:0] trim,
                                                   input int unsigned k);
    return trim[k*8 +: 8];
  endfunction

endpackage

// File: rtl/char_div_scale.sv
// char_div_scale: combinational multiply-shift-add, out = base + ((a * num) >> shift).
//   base  - signed W+2 addend
//   a     - unsigned W-bit operand
//   num   - unsigned runtime numerator (W+8 bits, product is 2W+8 bits)
//   shift - right shift applied to the full product before truncation
//   out   - signed W+2 sum
module char_div_scale #(
  parameter int unsigned W    = 12,
  parameter int unsigned SH_W = 5
) (
  input  logic signed [W+1:0]  base,
  input  logic        [W-1:0]  a,
  input  logic        [W+7:0]  num,
  input  logic        [SH_W-1:0] shift,
  output logic signed [W+1:0]  out
);

  localparam int unsigned PW = 2*W + 8;

  logic [PW-1:0] prod;

  always_comb begin
    prod = PW'(a) * PW'(num);
    // Shifted product is non-negative and truncated to the sum width.
    out  = base + $signed((W+2)'(prod >> shift));
  end

endmodule

// File: rtl/char_division_gen.sv
// char_division_gen: per-frame character segmentation geometry for the plate path.
//   clk, rst                    - pixel clock, synchronous active-high reset
//   i_x, i_y                    - current video position; TRIG_X/TRIG_Y starts a calculation
//   edge_left/right/up/down     - plate box, snapshotted at the trigger
//   partition_lines             - N_CHAR-1 vertical lines, line k at [k*W +: W]
//   char_up/down_position       - character vertical bounds
//   row_scanf_line1/2           - row-scan lines
//   valid                       - one-cycle pulse when outputs update
//   busy                        - calculation in progress
//   geom_err                    - last attempt rejected for degenerate geometry
module char_division_gen
  import char_div_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter int unsigned N_CHAR     = 7,
  parameter int unsigned TRIG_X     = 450,
  parameter int unsigned TRIG_Y     = 250,
  parameter int unsigned FIRST_NUM  = DEF_FIRST_NUM,
  parameter int unsigned PITCH_NUM  = DEF_PITCH_NUM,
  parameter int unsigned H_SHIFT    = DEF_H_SHIFT,
  parameter int unsigned MARGIN_NUM = DEF_MARGIN_NUM,
  parameter int unsigned V_SHIFT    = DEF_V_SHIFT,
  parameter int unsigned ROW1_NUM   = DEF_ROW1_NUM,
  parameter int unsigned ROW2_NUM   = DEF_ROW2_NUM,
  parameter int unsigned ROW_SHIFT  = DEF_ROW_SHIFT,
  parameter logic [(N_CHAR-1)*8-1:0] TRIM = ((N_CHAR-1)*8)'(DEF_TRIM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               i_x,
  input  logic [W-1:0]               i_y,
  input  logic [W-1:0]               edge_left,
  input  logic [W-1:0]               edge_right,
  input  logic [W-1:0]               edge_up,
  input  logic [W-1:0]               edge_down,
  output logic [(N_CHAR-1)*W-1:0]    partition_lines,
  output logic [W-1:0]               char_up_position,
  output logic [W-1:0]               char_down_position,
  output logic [W-1:0]               row_scanf_line1,
  output logic [W-1:0]               row_scanf_line2,
  output logic                       valid,
  output logic                       busy,
  output logic                       geom_err
);

  localparam int unsigned NL    = N_CHAR - 1;
  localparam int unsigned KW    = (NL > 1) ? $clog2(NL) : 1;
  localparam int unsigned SW    = W + 2;
  localparam int unsigned NUM_W = W + 8;
  localparam int unsigned SH_W  = 5;

  state_t state;

  logic [W-1:0]    sh_left, sh_right, sh_up, sh_down;
  logic [W-1:0]    up_s, dn_s, row1_s, row2_s;
  logic [NL*W-1:0] lines_s;
  logic [KW-1:0]   k;

  logic [W-1:0]          w_cur, h_cur, ch;
  logic signed [SW-1:0]  ch_full;
  logic [TRIM_MAX_W-1:0] trim_all;
  logic signed [7:0]     trim_k;

  logic signed [SW-1:0] a_base, a_out, b_base, b_out;
  logic [W-1:0]         a_a, b_a;
  logic [NUM_W-1:0]     a_num, b_num;
  logic [SH_W-1:0]      a_sh, b_sh;

  logic signed [SW-1:0] left_x, right_x;
  logic [W-1:0]         line_val;
  logic                 trig;

  always_comb begin
    trig     = (i_x == W'(TRIG_X)) && (i_y == W'(TRIG_Y));
    w_cur    = sh_right - sh_left;
    h_cur    = sh_down - sh_up;
    ch_full  = $signed({2'b00, dn_s}) - $signed({2'b00, up_s});
    ch       = (ch_full < 0) ? '0 : W'(ch_full);
    trim_all = TRIM_MAX_W'(TRIM);
    trim_k   = trim_slice(trim_all, 32'(k));
  end

  // Two shared scale units. In CALC_H unit B chains on unit A so the
  // first-offset and pitch terms are truncated separately.
  always_comb begin
    a_base = '0;
    a_a    = '0;
    a_num  = '0;
    a_sh   = '0;
    case (state)
      CALC_V: begin
        a_base = $signed({2'b00, sh_up});
        a_a    = h_cur;
        a_num  = NUM_W'(MARGIN_NUM);
        a_sh   = SH_W'(V_SHIFT);
      end
      CALC_ROW: begin
        a_base = $signed({2'b00, up_s});
        a_a    = ch;
        a_num  = NUM_W'(ROW1_NUM);
        a_sh   = SH_W'(ROW_SHIFT);
      end
      CALC_H: begin
        a_base = $signed({2'b00, sh_left}) + $signed({{(SW-8){trim_k[7]}}, trim_k});
        a_a    = w_cur;
        a_num  = NUM_W'(FIRST_NUM);
        a_sh   = SH_W'(H_SHIFT);
      end
      default: ;
    endcase
  end

  always_comb begin
    b_base = '0;
    b_a    = '0;
    b_num  = '0;
    b_sh   = '0;
    case (state)
      CALC_ROW: begin
        b_base = $signed({2'b00, up_s});
        b_a    = ch;
        b_num  = NUM_W'(ROW2_NUM);
        b_sh   = SH_W'(ROW_SHIFT);
      end
      CALC_H: begin
        b_base = a_out;
        b_a    = w_cur;
        b_num  = NUM_W'(k) * NUM_W'(PITCH_NUM);
        b_sh   = SH_W'(H_SHIFT);
      end
      default: ;
    endcase
  end

  char_div_scale #(.W(W), .SH_W(SH_W)) u_scale_a (
    .base  (a_base),
    .a     (a_a),
    .num   (a_num),
    .shift (a_sh),
    .out   (a_out)
  );

  char_div_scale #(.W(W), .SH_W(SH_W)) u_scale_b (
    .base  (b_base),
    .a     (b_a),
    .num   (b_num),
    .shift (b_sh),
    .out   (b_out)
  );

  // Clamp the partition line into [left, right] using the signed sum.
  always_comb begin
    left_x  = $signed({2'b00, sh_left});
    right_x = $signed({2'b00, sh_right});
    if (b_out < left_x) begin
      line_val = sh_left;
    end else if (b_out > right_x) begin
      line_val = sh_right;
    end else begin
      line_val = W'(b_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      sh_left            <= '0;
      sh_right           <= '0;
      sh_up              <= '0;
      sh_down            <= '0;
      up_s               <= '0;
      dn_s               <= '0;
      row1_s             <= '0;
      row2_s             <= '0;
      lines_s            <= '0;
      k                  <= '0;
      partition_lines    <= '0;
      char_up_position   <= '0;
      char_down_position <= '0;
      row_scanf_line1    <= '0;
      row_scanf_line2    <= '0;
      valid              <= 1'b0;
      busy               <= 1'b0;
      geom_err           <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            sh_left  <= edge_left;
            sh_right <= edge_right;
            sh_up    <= edge_up;
            sh_down  <= edge_down;
            busy     <= 1'b1;
            state    <= CALC_V;
          end
        end
        CALC_V: begin
          if ((sh_right <= sh_left) || (sh_down <= sh_up)) begin
            geom_err <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            // a_out = up + margin; the margin is recovered to trim the lower edge.
            up_s  <= W'(a_out);
            dn_s  <= W'($signed({2'b00, sh_down}) - (a_out - $signed({2'b00, sh_up})));
            state <= CALC_ROW;
          end
        end
        CALC_ROW: begin
          row1_s <= W'(a_out);
          row2_s <= W'(b_out);
          k      <= '0;
          state  <= CALC_H;
        end
        CALC_H: begin
          lines_s[int'(k)*W +: W] <= line_val;
          if (k == KW'(NL - 1)) begin
            state <= COMMIT;
          end else begin
            k <= k + 1'b1;
          end
        end
        COMMIT: begin
          partition_lines    <= lines_s;
          char_up_position   <= up_s;
          char_down_position <= dn_s;
          row_scanf_line1    <= row1_s;
          row_scanf_line2    <= row2_s;
          valid              <= 1'b1;
          geom_err           <= 1'b0;
          busy               <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_division_gen.sv
// tb_char_division_gen: scoreboard bench for char_division_gen. A second
// instance with trim slice 5 = +40 exercises the right-edge clamp.
module tb_char_division_gen;

  typedef struct packed {
    logic [5:0][11:0] lines;
    logic [11:0] up;
    logic [11:0] dn;
    logic [11:0] r1;
    logic [11:0] r2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] i_x = '0, i_y = '0;
  logic [11:0] edge_left = '0, edge_right = '0, edge_up = '0, edge_down = '0;

  logic [71:0] pl, pl_c;
  logic [11:0] up, dn, r1, r2, up_c, dn_c, r1_c, r2_c;
  logic        valid, busy, geom_err, valid_c, busy_c, geom_err_c;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];
  exp_t qc[$];
  int nom[6] = '{205, 250, 295, 338, 381, 419};

  always #5 clk = ~clk;

  char_division_gen dut (
    .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y),
    .edge_left(edge_left), .edge_right(edge_right), .edge_up(edge_up), .edge_down(edge_down),
    .partition_lines(pl), .char_up_position(up), .char_down_position(dn),
    .row_scanf_line1(r1), .row_scanf_line2(r2),
    .valid(valid), .busy(busy), .geom_err(geom_err)
  );

  char_division_gen #(.TRIM(48'h28_FC_FE_00_00_00)) dut_c (
    .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y),
    .edge_left(edge_left), .edge_right(edge_right), .edge_up(edge_up), .edge_down(edge_down),
    .partition_lines(pl_c), .char_up_position(up_c), .char_down_position(dn_c),
    .row_scanf_line1(r1_c), .row_scanf_line2(r2_c),
    .valid(valid_c), .busy(busy_c), .geom_err(geom_err_c)
  );

  function automatic exp_t model(input int l, input int r, input int u, input int d,
                                 input bit clamp_trim);
    exp_t e;
    int tr[6];
    int w, h, m, upv, dnv, ch, f, v;
    tr = '{0, 0, 0, -2, -4, -11};
    if (clamp_trim) tr[5] = 40;
    w   = r - l;
    h   = d - u;
    m   = (3 * h) / 32;
    upv = u + m;
    dnv = d - m;
    ch  = dnv - upv;
    if (ch < 0) ch = 0;
    e.up = 12'(upv);
    e.dn = 12'(dnv);
    e.r1 = 12'(upv + (5 * ch) / 16);
    e.r2 = 12'(upv + (12 * ch) / 16);
    f = (21 * w) / 64;
    for (int k = 0; k < 6; k++) begin
      v = l + f + (k * 9 * w) / 64 + tr[k];
      if (v < l) v = l;
      if (v > r) v = r;
      e.lines[k] = 12'(v);
    end
    return e;
  endfunction

  task automatic idle(input int n, output int vcnt);
    vcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
    end
  endtask

  // Drives one frame; hold = edges the trigger stays asserted, zap = edge
  // after which all box edges are forced to 0 (-1 for never).
  task automatic run_frame(input int l, input int r, input int u, input int d,
                           input int hold, input int zap,
                           output int lat, output int busy_bad);
    exp_t e, ec;
    edge_left = 12'(l); edge_right = 12'(r); edge_up = 12'(u); edge_down = 12'(d);
    q.push_back(model(l, r, u, d, 1'b0));
    qc.push_back(model(l, r, u, d, 1'b1));
    i_x = 12'd450; i_y = 12'd250;
    @(posedge clk); #1;
    lat = -1;
    busy_bad = busy ? 0 : 1;
    if (hold <= 1) begin i_x = '0; i_y = '0; end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == hold - 1) begin i_x = '0; i_y = '0; end
      if (n == zap) begin
        edge_left = '0; edge_right = '0; edge_up = '0; edge_down = '0;
      end
      if (valid) begin
        lat = n;
        break;
      end
      if (!busy) busy_bad++;
    end
    i_x = '0; i_y = '0;
    if (lat >= 0) begin
      if (busy) busy_bad++;
      e  = q.pop_front();
      ec = qc.pop_front();
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (pl[k*12 +: 12] !== e.lines[k]) begin
          failures++;
          $display("FAIL sb_line%0d got=%0d exp=%0d", k, pl[k*12 +: 12], e.lines[k]);
        end
        checks++;
        if (pl_c[k*12 +: 12] !== ec.lines[k]) begin
          failures++;
          $display("FAIL sb_clamp_line%0d got=%0d exp=%0d", k, pl_c[k*12 +: 12], ec.lines[k]);
        end
      end
      checks++;
      if (up !== e.up) begin failures++; $display("FAIL sb_up got=%0d exp=%0d", up, e.up); end
      checks++;
      if (dn !== e.dn) begin failures++; $display("FAIL sb_down got=%0d exp=%0d", dn, e.dn); end
      checks++;
      if (r1 !== e.r1) begin failures++; $display("FAIL sb_row1 got=%0d exp=%0d", r1, e.r1); end
      checks++;
      if (r2 !== e.r2) begin failures++; $display("FAIL sb_row2 got=%0d exp=%0d", r2, e.r2); end
      checks++;
      if (valid_c !== 1'b1) begin failures++; $display("FAIL sb_valid_c got=%b exp=1", valid_c); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pl !== '0) begin failures++; $display("FAIL rst_lines got=%h exp=0", pl); end
    checks++; if (up !== '0) begin failures++; $display("FAIL rst_up got=%0d exp=0", up); end
    checks++; if (dn !== '0) begin failures++; $display("FAIL rst_down got=%0d exp=0", dn); end
    checks++; if (r1 !== '0 || r2 !== '0) begin failures++; $display("FAIL rst_rows got=%0d/%0d exp=0/0", r1, r2); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (geom_err !== 1'b0) begin failures++; $display("FAIL rst_geom_err got=%b exp=0", geom_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_nominal_consts(input string tag);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pl[k*12 +: 12] !== 12'(nom[k])) begin
        failures++;
        $display("FAIL %s_line%0d got=%0d exp=%0d", tag, k, pl[k*12 +: 12], nom[k]);
      end
    end
    checks++;
    if (up !== 12'd209 || dn !== 12'd287 || r1 !== 12'd233 || r2 !== 12'd267) begin
      failures++;
      $display("FAIL %s_bounds got=%0d/%0d/%0d/%0d exp=209/287/233/267", tag, up, dn, r1, r2);
    end
  endtask

  task automatic test_nominal;
    int lat, bb;
    run_frame(100, 420, 200, 296, 1, -1, lat, bb);
    checks++; if (lat != 9) begin failures++; $display("FAIL nom_latency got=%0d exp=9", lat); end
    checks++; if (bb != 0) begin failures++; $display("FAIL nom_busy_profile got=%0d bad edges exp=0", bb); end
    check_nominal_consts("nom");
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL nom_valid_width got=%b exp=0", valid); end
  endtask

  task automatic test_degenerate;
    int lat, bb, v;
    edge_left = 12'd300; edge_right = 12'd300; edge_up = 12'd200; edge_down = 12'd296;
    i_x = 12'd450; i_y = 12'd250;
    @(posedge clk); #1;
    i_x = '0; i_y = '0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL deg_busy_e0 got=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++; if (geom_err !== 1'b1) begin failures++; $display("FAIL deg_geom_err got=%b exp=1", geom_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL deg_busy_e1 got=%b exp=0", busy); end
    idle(12, v);
    checks++; if (v != 0) begin failures++; $display("FAIL deg_no_valid got=%0d pulses exp=0", v); end
    checks++; if (geom_err !== 1'b1) begin failures++; $display("FAIL deg_geom_hold got=%b exp=1", geom_err); end
    check_nominal_consts("deg_hold");
    run_frame(100, 420, 200, 296, 1, -1, lat, bb);
    checks++; if (lat != 9) begin failures++; $display("FAIL deg_recover_latency got=%0d exp=9", lat); end
    checks++; if (geom_err !== 1'b0) begin failures++; $display("FAIL deg_geom_clear got=%b exp=0", geom_err); end
  endtask

  task automatic test_snapshot;
    int lat, bb;
    // Outputs first moved away from the nominal values so the check is meaningful.
    run_frame(50, 300, 100, 180, 1, -1, lat, bb);
    checks++; if (lat != 9) begin failures++; $display("FAIL snap_pre_latency got=%0d exp=9", lat); end
    run_frame(100, 420, 200, 296, 1, 2, lat, bb);
    checks++; if (lat != 9) begin failures++; $display("FAIL snap_latency got=%0d exp=9", lat); end
    check_nominal_consts("snap");
  endtask

  task automatic test_retrigger;
    int lat, bb, v;
    run_frame(80, 400, 150, 250, 3, -1, lat, bb);
    checks++; if (lat != 9) begin failures++; $display("FAIL retrig_latency got=%0d exp=9", lat); end
    checks++; if (bb != 0) begin failures++; $display("FAIL retrig_busy_profile got=%0d exp=0", bb); end
    idle(15, v);
    checks++; if (v != 0) begin failures++; $display("FAIL retrig_extra_valid got=%0d exp=0", v); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL retrig_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_clamp;
    int lat, bb;
    run_frame(100, 140, 200, 296, 1, -1, lat, bb);
    checks++; if (lat != 9) begin failures++; $display("FAIL clamp_latency got=%0d exp=9", lat); end
    checks++; if (pl_c[71:60] !== 12'd140) begin failures++; $display("FAIL clamp_line5 got=%0d exp=140", pl_c[71:60]); end
    checks++; if (pl[71:60] !== 12'd130) begin failures++; $display("FAIL clamp_default_line5 got=%0d exp=130", pl[71:60]); end
  endtask

  task automatic test_reset_mid;
    int lat, bb, v;
    edge_left = 12'd100; edge_right = 12'd420; edge_up = 12'd200; edge_down = 12'd296;
    i_x = 12'd450; i_y = 12'd250;
    @(posedge clk); #1;
    i_x = '0; i_y = '0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (pl !== '0) begin failures++; $display("FAIL rmid_lines got=%h exp=0", pl); end
    checks++; if (up !== '0 || dn !== '0 || r1 !== '0 || r2 !== '0) begin
      failures++; $display("FAIL rmid_bounds got=%0d/%0d/%0d/%0d exp=0", up, dn, r1, r2);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", valid); end
    rst = 1'b0;
    idle(12, v);
    checks++; if (v != 0) begin failures++; $display("FAIL rmid_no_valid got=%0d exp=0", v); end
    checks++; if (pl !== '0) begin failures++; $display("FAIL rmid_lines_hold got=%h exp=0", pl); end
    run_frame(100, 420, 200, 296, 1, -1, lat, bb);
    checks++; if (lat != 9) begin failures++; $display("FAIL rmid_recover_latency got=%0d exp=9", lat); end
    check_nominal_consts("rmid");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_degenerate();
    test_snapshot();
    test_retrigger();
    test_clamp();
    test_reset_mid();
    checks++;
    if (q.size() != 0 || qc.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d/%0d exp=0/0", q.size(), qc.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
